// File: rtl/ebi_pkg.sv
// Shared types and widths for the SAM9 EBI slave port controller.
package ebi_pkg;
  localparam int IDX_W  = 6;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 25;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_WR_HOLD,
    ST_ERR
  } ebi_state_e;
endpackage

// File: rtl/ebi_slave_ctrl_if.sv
// EBI pad-side bundle: address, chip selects, strobes and IOBUF data/tristate.
interface ebi_slave_ctrl_if;
  import ebi_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic [1:0]        cs;
  logic              rd;
  logic              wr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              dout_t;

  modport slave  (input  addr, cs, rd, wr, din, output dout, dout_t);
  modport master (output addr, cs, rd, wr, din, input  dout, dout_t);
endinterface

// File: rtl/ebi_sync2.sv
// Two-flop synchroniser for one asynchronous control line.
module ebi_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/ebi_slave_ctrl.sv
// SAM9 SMC/EBI slave: synchronised strobe decode, transaction FSM and a
// register bank shared between the CPU bus and one internal writer.
module ebi_slave_ctrl
  import ebi_pkg::*;
#(
  parameter int                NREGS    = 8,
  parameter logic [DATA_W-1:0] ID_VALUE = 16'hB001,
  parameter int                ADDR_LSB = 1,
  parameter int                CS_SEL   = 0
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  ebi_slave_ctrl_if.slave         bus,
  input  logic                    usr_wr_req_i,
  input  logic [IDX_W-1:0]        usr_wr_idx_i,
  input  logic [DATA_W-1:0]       usr_wr_data_i,
  output logic                    usr_wr_ack_o,
  output logic                    bus_wr_stb_o,
  output logic [IDX_W-1:0]        bus_wr_idx_o,
  output logic [NREGS*DATA_W-1:0] regs_o,
  output logic                    proto_err_o
);
  logic cs_s, rd_s, wr_s;

  ebi_sync2 #(.RST_VAL(1'b1)) u_sync_cs (.clk_i(clk_i), .rst_ni(reset_i), .d_i(bus.cs[CS_SEL]), .q_o(cs_s));
  ebi_sync2 #(.RST_VAL(1'b1)) u_sync_rd (.clk_i(clk_i), .rst_ni(reset_i), .d_i(bus.rd), .q_o(rd_s));
  ebi_sync2 #(.RST_VAL(1'b1)) u_sync_wr (.clk_i(clk_i), .rst_ni(reset_i), .d_i(bus.wr), .q_o(wr_s));

  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.addr, bus.cs};

  ebi_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_t_q, dout_t_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  logic [IDX_W-1:0]  addr_idx;
  logic [DATA_W-1:0] rd_val;
  logic              bus_hit;
  logic              usr_ack;

  assign addr_idx = bus.addr[ADDR_LSB +: IDX_W];

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dout_d   = dout_q;
    dout_t_d = dout_t_q;
    err_d    = err_q;
    regs_d   = regs_q;
    rd_val   = '0;
    bus_hit  = 1'b0;
    usr_ack  = 1'b0;

    // Slot 0 holds the constant ID, so a uniform lookup covers reg 0 too.
    for (int k = 0; k < NREGS; k++) begin
      if (addr_idx == IDX_W'(k)) rd_val = regs_q[k];
    end

    case (state_q)
      ST_IDLE: begin
        idx_d = addr_idx;
        if (!cs_s) begin
          if (!rd_s && !wr_s) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else if (!rd_s) begin
            state_d  = ST_RD;
            dout_d   = rd_val;
            dout_t_d = 1'b0;
          end else if (!wr_s) begin
            state_d = ST_WR;
          end
        end
      end
      ST_RD: begin
        if (rd_s || cs_s) begin
          state_d  = ST_IDLE;
          dout_t_d = 1'b1;
        end
      end
      ST_WR: begin
        for (int k = 1; k < NREGS; k++) begin
          if (idx_q == IDX_W'(k)) begin
            regs_d[k] = bus.din;
            bus_hit   = 1'b1;
          end
        end
        state_d = ST_WR_HOLD;
      end
      ST_WR_HOLD: begin
        if (wr_s || cs_s) state_d = ST_IDLE;
      end
      ST_ERR: begin
        if (rd_s && wr_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Bus wins a same-register collision; the held request lands next cycle.
    usr_ack = usr_wr_req_i && !(state_q == ST_WR && usr_wr_idx_i == idx_q);
    if (usr_ack) begin
      for (int k = 1; k < NREGS; k++) begin
        if (usr_wr_idx_i == IDX_W'(k)) regs_d[k] = usr_wr_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      dout_q   <= '0;
      dout_t_q <= 1'b1;
      err_q    <= 1'b0;
      regs_q[0] <= ID_VALUE;
      for (int k = 1; k < NREGS; k++) regs_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      dout_q   <= dout_d;
      dout_t_q <= dout_t_d;
      err_q    <= err_d;
      for (int k = 0; k < NREGS; k++) regs_q[k] <= regs_d[k];
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_regs_o
    assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign bus.dout     = dout_q;
  assign bus.dout_t   = dout_t_q;
  assign usr_wr_ack_o = usr_ack;
  assign bus_wr_stb_o = bus_hit;
  assign bus_wr_idx_o = idx_q;
  assign proto_err_o  = err_q;
endmodule

// File: tb/tb_ebi_slave_ctrl.sv
// Directed bench for ebi_slave_ctrl: reset, bus read/write, collisions,
// out-of-range access, protocol error and mid-read reset.
module tb_ebi_slave_ctrl;
  import ebi_pkg::*;

  localparam int NREGS = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic usr_req = 1'b0;
  logic [IDX_W-1:0]  usr_idx = '0;
  logic [DATA_W-1:0] usr_data = '0;
  logic usr_ack;
  logic bus_stb;
  logic [IDX_W-1:0] bus_idx;
  logic [NREGS*DATA_W-1:0] regs;
  logic proto_err;

  int checks = 0;
  int errors = 0;
  int stb_cnt = 0;
  logic [IDX_W-1:0] stb_idx = '0;

  ebi_slave_ctrl_if bus_if ();

  ebi_slave_ctrl #(.NREGS(NREGS), .ID_VALUE(16'hB001), .ADDR_LSB(1), .CS_SEL(0)) dut (
    .clk_i(clk), .reset_i(rst_n), .bus(bus_if.slave),
    .usr_wr_req_i(usr_req), .usr_wr_idx_i(usr_idx), .usr_wr_data_i(usr_data),
    .usr_wr_ack_o(usr_ack), .bus_wr_stb_o(bus_stb), .bus_wr_idx_o(bus_idx),
    .regs_o(regs), .proto_err_o(proto_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus_stb) begin
      stb_cnt = stb_cnt + 1;
      stb_idx = bus_idx;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [DATA_W-1:0] reg_at(input int k);
    return regs[k*DATA_W +: DATA_W];
  endfunction

  task automatic bus_write(input logic [24:0] a, input logic [15:0] d);
    bus_if.addr = a; bus_if.cs = 2'b10;
    repeat (3) tick();
    bus_if.din = d; bus_if.wr = 1'b0;
    repeat (6) tick();
    bus_if.wr = 1'b1;
    repeat (3) tick();
    bus_if.cs = 2'b11;
    repeat (3) tick();
  endtask

  task automatic bus_read(input logic [24:0] a, output logic [15:0] d,
                          output logic t_on, output logic t_off);
    bus_if.addr = a; bus_if.cs = 2'b10;
    repeat (3) tick();
    bus_if.rd = 1'b0;
    repeat (6) tick();
    @(negedge clk); d = bus_if.dout; t_on = bus_if.dout_t;
    tick();
    bus_if.rd = 1'b1;
    repeat (4) tick();
    @(negedge clk); t_off = bus_if.dout_t;
    tick();
    bus_if.cs = 2'b11;
    repeat (3) tick();
  endtask

  // The FSM sits in WR during the fourth cycle after NWE falls; the user
  // request is raised exactly for that cycle.
  task automatic bus_write_usr(input logic [24:0] a, input logic [15:0] d,
                               input logic [IDX_W-1:0] ui, input logic [15:0] ud,
                               output logic ack_wr, output logic ack_next);
    bus_if.addr = a; bus_if.cs = 2'b10;
    repeat (3) tick();
    bus_if.din = d; bus_if.wr = 1'b0;
    repeat (3) tick();
    usr_req = 1'b1; usr_idx = ui; usr_data = ud;
    @(negedge clk); ack_wr = usr_ack;
    tick();
    if (ack_wr) usr_req = 1'b0;
    @(negedge clk); ack_next = usr_ack;
    tick();
    usr_req = 1'b0;
    repeat (2) tick();
    bus_if.wr = 1'b1;
    repeat (3) tick();
    bus_if.cs = 2'b11;
    repeat (3) tick();
  endtask

  initial begin
    logic [15:0] d;
    logic t_on, t_off, a1, a2;
    int snap;

    bus_if.addr = '0; bus_if.cs = 2'b11; bus_if.rd = 1'b1; bus_if.wr = 1'b1; bus_if.din = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // 1: reset state and ID readback
    chk("rst_data_t", 32'(bus_if.dout_t), 32'd1);
    chk("rst_data_o", 32'(bus_if.dout), 32'd0);
    chk("rst_proto_err", 32'(proto_err), 32'd0);
    chk("rst_stb", 32'(bus_stb), 32'd0);
    for (int k = 1; k < NREGS; k++) chk($sformatf("rst_reg%0d", k), 32'(reg_at(k)), 32'd0);
    bus_read(25'h000000, d, t_on, t_off);
    chk("id_read", 32'(d), 32'hB001);

    // 2: write then read back reg 3
    stb_cnt = 0;
    bus_write(25'h000006, 16'h1234);
    chk("wr3_stb_cnt", 32'(stb_cnt), 32'd1);
    chk("wr3_stb_idx", 32'(stb_idx), 32'd3);
    chk("wr3_reg", 32'(reg_at(3)), 32'h1234);
    chk("pre_read_t", 32'(bus_if.dout_t), 32'd1);
    bus_read(25'h000006, d, t_on, t_off);
    chk("rd3_data", 32'(d), 32'h1234);
    chk("rd3_t_low", 32'(t_on), 32'd0);
    chk("rd3_t_high", 32'(t_off), 32'd1);

    // 3: same-register collision, then different-register concurrency
    bus_write_usr(25'h000004, 16'hAAAA, 6'd2, 16'h5555, a1, a2);
    chk("coll_ack_wr", 32'(a1), 32'd0);
    chk("coll_ack_next", 32'(a2), 32'd1);
    chk("coll_reg2", 32'(reg_at(2)), 32'h5555);
    bus_write_usr(25'h000004, 16'h1111, 6'd4, 16'h5555, a1, a2);
    chk("par_ack_wr", 32'(a1), 32'd1);
    chk("par_ack_next", 32'(a2), 32'd0);
    chk("par_reg2", 32'(reg_at(2)), 32'h1111);
    chk("par_reg4", 32'(reg_at(4)), 32'h5555);

    // 4: out-of-range index
    snap = stb_cnt;
    bus_write(25'h000020, 16'hFFFF);
    chk("oor_stb", 32'(stb_cnt), 32'(snap));
    chk("oor_reg2", 32'(reg_at(2)), 32'h1111);
    chk("oor_reg3", 32'(reg_at(3)), 32'h1234);
    chk("oor_reg4", 32'(reg_at(4)), 32'h5555);
    chk("oor_reg7", 32'(reg_at(7)), 32'h0000);
    bus_read(25'h000020, d, t_on, t_off);
    chk("oor_read", 32'(d), 32'h0000);

    // 5: NRD and NWE low together
    snap = stb_cnt;
    bus_if.addr = 25'h000006; bus_if.cs = 2'b10; bus_if.din = 16'hDEAD;
    repeat (3) tick();
    bus_if.rd = 1'b0; bus_if.wr = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    chk("err_t", 32'(bus_if.dout_t), 32'd1);
    chk("err_flag", 32'(proto_err), 32'd1);
    tick();
    bus_if.rd = 1'b1; bus_if.wr = 1'b1;
    repeat (4) tick();
    bus_if.cs = 2'b11;
    repeat (3) tick();
    chk("err_sticky", 32'(proto_err), 32'd1);
    chk("err_reg3", 32'(reg_at(3)), 32'h1234);
    chk("err_stb", 32'(stb_cnt), 32'(snap));
    bus_read(25'h000006, d, t_on, t_off);
    chk("post_err_read", 32'(d), 32'h1234);
    chk("post_err_t_low", 32'(t_on), 32'd0);

    // 6: reset in the middle of a read
    bus_if.addr = 25'h000006; bus_if.cs = 2'b10;
    repeat (3) tick();
    bus_if.rd = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    chk("midrd_t_before", 32'(bus_if.dout_t), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrd_t_async", 32'(bus_if.dout_t), 32'd1);
    chk("midrd_err_clr", 32'(proto_err), 32'd0);
    bus_if.rd = 1'b1; bus_if.cs = 2'b11;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) tick();
    chk("midrd_reg3_clr", 32'(reg_at(3)), 32'd0);
    bus_read(25'h000000, d, t_on, t_off);
    chk("midrd_id_read", 32'(d), 32'hB001);
    chk("midrd_t_high", 32'(t_off), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
